// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - two-master (fetch/data) arbiter onto a single-ported unified memory
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction side
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  // data side
  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wr_i,
  input  logic [31:0] dmem_wr_data_i,
  input  logic [1:0]  dmem_byte_en_i,
  input  logic        dmem_zero_extnd_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  // unified memory
  output logic        mem_req_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_zero_extnd_o,
  input  logic [31:0] mem_rd_data_i
);

  // Counter is at least one bit wide so a zero limit still elaborates.
  localparam int              CW           = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX   = CW'(STARVE_LIMIT);
  localparam logic            OWNER_IMEM   = 1'b0;
  localparam logic            OWNER_DMEM   = 1'b1;
  // Fetches are always full-word, zero-extend is meaningless for them.
  localparam logic [1:0]      IMEM_BYTE_EN = 2'b10;

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          lock_valid_q, lock_valid_d;
  logic          lock_owner_q, lock_owner_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_owner_q, resp_owner_d;

  logic          req_any;
  logic          lock_hold;
  logic          sel_owner;
  logic          xfer;

  // Owner selection: a live lock wins, then dmem priority unless imem is starved.
  always_comb begin
    req_any   = (imem_req_i | dmem_req_i) & ~reset;
    // A lock only holds while its owner is still asking; otherwise re-arbitrate.
    lock_hold = lock_valid_q & ((lock_owner_q == OWNER_DMEM) ? dmem_req_i : imem_req_i);
    if (lock_hold) begin
      sel_owner = lock_owner_q;
    end else if (imem_req_i & dmem_req_i) begin
      sel_owner = (starve_cnt_q == STARVE_MAX) ? OWNER_IMEM : OWNER_DMEM;
    end else if (dmem_req_i) begin
      sel_owner = OWNER_DMEM;
    end else begin
      sel_owner = OWNER_IMEM;
    end
    xfer = req_any & mem_ready_i;
  end

  // Memory-side payload mux; all-zero whenever nobody is requesting.
  always_comb begin
    mem_req_o        = req_any;
    mem_addr_o       = 32'h0;
    mem_wr_o         = 1'b0;
    mem_wr_data_o    = 32'h0;
    mem_byte_en_o    = 2'b00;
    mem_zero_extnd_o = 1'b0;
    if (req_any) begin
      if (sel_owner == OWNER_DMEM) begin
        mem_addr_o       = dmem_addr_i;
        mem_wr_o         = dmem_wr_i;
        mem_wr_data_o    = dmem_wr_data_i;
        mem_byte_en_o    = dmem_byte_en_i;
        mem_zero_extnd_o = dmem_zero_extnd_i;
      end else begin
        mem_addr_o       = imem_addr_i;
        mem_byte_en_o    = IMEM_BYTE_EN;
      end
    end
  end

  // Requester-side grants and read responses; reset forces everything quiet.
  always_comb begin
    imem_gnt_o    = xfer & (sel_owner == OWNER_IMEM);
    dmem_gnt_o    = xfer & (sel_owner == OWNER_DMEM);
    imem_rvalid_o = resp_valid_q & (resp_owner_q == OWNER_IMEM) & ~reset;
    dmem_rvalid_o = resp_valid_q & (resp_owner_q == OWNER_DMEM) & ~reset;
    imem_rdata_o  = imem_rvalid_o ? mem_rd_data_i : 32'h0;
    dmem_rdata_o  = dmem_rvalid_o ? mem_rd_data_i : 32'h0;
  end

  // Next-state for starvation counter, lock and pending read response.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!imem_req_i || (xfer && sel_owner == OWNER_IMEM)) begin
      starve_cnt_d = '0;
    end else if (xfer && sel_owner == OWNER_DMEM && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    // Stalled request pins the owner so its payload is not swapped mid-handshake.
    lock_valid_d = req_any & ~mem_ready_i;
    lock_owner_d = sel_owner;

    resp_valid_d = xfer & ~mem_wr_o;
    resp_owner_d = sel_owner;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_IMEM;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_IMEM;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_i = 1'b0;
  logic [31:0] imem_addr_i = 32'h0;
  logic        imem_gnt_o, imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i = 1'b0;
  logic [31:0] dmem_addr_i = 32'h0;
  logic        dmem_wr_i = 1'b0;
  logic [31:0] dmem_wr_data_i = 32'h0;
  logic [1:0]  dmem_byte_en_i = 2'b00;
  logic        dmem_zero_extnd_i = 1'b0;
  logic        dmem_gnt_o, dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_zero_extnd_o;
  logic [31:0] mem_rd_data_i = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_wr_i(dmem_wr_i),
    .dmem_wr_data_i(dmem_wr_data_i), .dmem_byte_en_i(dmem_byte_en_i),
    .dmem_zero_extnd_i(dmem_zero_extnd_i), .dmem_gnt_o(dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_zero_extnd_o(mem_zero_extnd_o), .mem_rd_data_i(mem_rd_data_i)
  );

  // Memory contents as a pure function of address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: owner is -1 (none), 0 (imem) or 1 (dmem).
  int          m_starve = 0;
  int          m_lock = -1;
  int          m_resp = -1;
  logic [31:0] m_rdata = 32'h0;

  function automatic int model_owner();
    if (reset || !(imem_req_i || dmem_req_i)) return -1;
    if (m_lock == 1 && dmem_req_i) return 1;
    if (m_lock == 0 && imem_req_i) return 0;
    if (imem_req_i && dmem_req_i) return (m_starve >= LIMIT) ? 0 : 1;
    return dmem_req_i ? 1 : 0;
  endfunction

  // Advance the model at each edge and play the memory's read-data response.
  always @(posedge clk) begin
    int          o;
    logic        x;
    logic [31:0] a;
    o = model_owner();
    x = (o >= 0) && mem_ready_i;
    a = (o == 1) ? dmem_addr_i : imem_addr_i;
    if (reset) begin
      m_starve = 0;
      m_lock   = -1;
      m_resp   = -1;
    end else begin
      m_resp = (x && !(o == 1 && dmem_wr_i)) ? o : -1;
      if (!imem_req_i || (x && o == 0)) m_starve = 0;
      else if (x && o == 1 && m_starve < LIMIT) m_starve++;
      m_lock = (o >= 0 && !mem_ready_i) ? o : -1;
    end
    m_rdata = (m_resp >= 0) ? memfn(a) : 32'($urandom);
    mem_rd_data_i = m_rdata;
  end

  // Compare every output against the model each cycle, away from the clock edge.
  always @(negedge clk) begin
    int o;
    logic x;
    o = model_owner();
    x = (o >= 0) && mem_ready_i;
    chk("mem_req", 32'(mem_req_o), 32'(o >= 0));
    chk("mem_addr", mem_addr_o, (o == 0) ? imem_addr_i : (o == 1) ? dmem_addr_i : 32'h0);
    chk("mem_wr", 32'(mem_wr_o), 32'(o == 1 && dmem_wr_i));
    chk("mem_wr_data", mem_wr_data_o, (o == 1) ? dmem_wr_data_i : 32'h0);
    chk("mem_byte_en", 32'(mem_byte_en_o), (o == 0) ? 32'd2 : (o == 1) ? 32'(dmem_byte_en_i) : 32'd0);
    chk("mem_zext", 32'(mem_zero_extnd_o), 32'(o == 1 && dmem_zero_extnd_i));
    chk("imem_gnt", 32'(imem_gnt_o), 32'(x && o == 0));
    chk("dmem_gnt", 32'(dmem_gnt_o), 32'(x && o == 1));
    chk("imem_rvalid", 32'(imem_rvalid_o), 32'(!reset && m_resp == 0));
    chk("dmem_rvalid", 32'(dmem_rvalid_o), 32'(!reset && m_resp == 1));
    chk("imem_rdata", imem_rdata_o, (!reset && m_resp == 0) ? m_rdata : 32'h0);
    chk("dmem_rdata", dmem_rdata_o, (!reset && m_resp == 1) ? m_rdata : 32'h0);
  end

  // Apply one cycle of inputs just after the edge, return shortly before the next.
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic dw,
                       input logic [31:0] dd, input logic [1:0] db, input logic dz,
                       input logic rdy);
    @(posedge clk);
    #1;
    cyc++;
    reset = r; imem_req_i = ir; imem_addr_i = ia;
    dmem_req_i = dr; dmem_addr_i = da; dmem_wr_i = dw; dmem_wr_data_i = dd;
    dmem_byte_en_i = db; dmem_zero_extnd_i = dz; mem_ready_i = rdy;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
  endtask

  logic [9:0] gpat;
  logic [7:0] rdy_pat;

  initial begin
    // Reset with both requesters active: everything must stay quiet.
    drive(1'b1, 1'b1, 32'h4, 1'b1, 32'h8, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_gnt", 32'({imem_gnt_o, dmem_gnt_o}), 32'd0);
    drive(1'b1, 1'b1, 32'h4, 1'b1, 32'h8, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
    chk("rst_addr", mem_addr_o, 32'h0);

    // Back-to-back fetches 0x0, 0x4, 0x8.
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("f0_gnt", 32'(imem_gnt_o), 32'd1);
    chk("f0_rvalid", 32'(imem_rvalid_o), 32'd0);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("f1_gnt", 32'(imem_gnt_o), 32'd1);
    chk("f0_data", imem_rdata_o, 32'h5A5A_0000);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("f1_data", imem_rdata_o, 32'h5A5A_0004);
    idle();
    chk("f2_rvalid", 32'(imem_rvalid_o), 32'd1);
    chk("f2_data", imem_rdata_o, 32'h5A5A_0008);

    // Continuous contention: expect D,D,D,D,I repeating.
    gpat = '0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h140, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
      gpat = {gpat[8:0], dmem_gnt_o};
      if (i == 4) chk("model_starve_at_limit", 32'(m_starve), 32'd4);
      if (i == 5) chk("model_starve_cleared", 32'(m_starve), 32'd0);
    end
    chk("starve_pattern", 32'(gpat), 32'(10'b1111011110));
    idle();

    // Contention under a ready stall pattern (model-checked).
    rdy_pat = 8'b1011_0111;
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 32'h44, 1'b1, 32'h144, 1'b0, 32'h0, 2'b10, 1'b0, rdy_pat[7-i]);
    idle();

    // dmem read stalled 3 cycles, imem arrives in cycle 2.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("stall1_dgnt", 32'(dmem_gnt_o), 32'd0);
    drive(1'b0, 1'b1, 32'h50, 1'b1, 32'h100, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("stall2_addr", mem_addr_o, 32'h100);
    drive(1'b0, 1'b1, 32'h50, 1'b1, 32'h100, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("stall3_ignt", 32'(imem_gnt_o), 32'd0);
    drive(1'b0, 1'b1, 32'h50, 1'b1, 32'h100, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
    chk("stall4_dgnt", 32'(dmem_gnt_o), 32'd1);
    chk("stall4_ignt", 32'(imem_gnt_o), 32'd0);
    drive(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("stall5_drvalid", 32'(dmem_rvalid_o), 32'd1);
    chk("stall5_ddata", dmem_rdata_o, 32'h5A5A_0100);
    chk("stall5_ignt", 32'(imem_gnt_o), 32'd1);
    idle();

    // Lock on imem must survive a later dmem request despite dmem priority.
    drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("ilock_addr", mem_addr_o, 32'h80);
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
    chk("ilock_gnt", 32'(imem_gnt_o), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
    chk("ilock_after_dgnt", 32'(dmem_gnt_o), 32'd1);

    // Locked dmem drops its request: imem is selected immediately.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("release_ignt", 32'(imem_gnt_o), 32'd1);
    chk("release_addr", mem_addr_o, 32'h90);

    // Write: payload forwarded, no response.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1);
    chk("wr_mem_wr", 32'(mem_wr_o), 32'd1);
    chk("wr_data", mem_wr_data_o, 32'hDEAD_BEEF);
    chk("wr_be", 32'(mem_byte_en_o), 32'd2);
    chk("wr_dgnt", 32'(dmem_gnt_o), 32'd1);
    // Halfword zero-extended load right behind the write.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h202, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1);
    chk("wr_no_rvalid", 32'(dmem_rvalid_o), 32'd0);
    chk("ld_zext", 32'(mem_zero_extnd_o), 32'd1);
    chk("ld_be", 32'(mem_byte_en_o), 32'd1);
    idle();
    chk("ld_data", dmem_rdata_o, 32'h5A5A_0202);

    // Reset lands on the cycle after a grant and on the cycle of a would-be grant.
    drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("rb_gnt", 32'(imem_gnt_o), 32'd1);
    drive(1'b1, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("rb_rvalid_gated", 32'(imem_rvalid_o), 32'd0);
    chk("rb_gnt_gated", 32'(imem_gnt_o), 32'd0);
    drive(1'b1, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("rb_no_rvalid", 32'(imem_rvalid_o), 32'd0);
    drive(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("rb_first_gnt", 32'(imem_gnt_o), 32'd1);
    chk("rb_first_rvalid", 32'(imem_rvalid_o), 32'd0);
    idle();
    chk("rb_data", imem_rdata_o, 32'h5A5A_0014);
    idle();

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
